// File: rtl/mips_multicycle_controller_if.sv
// rtl/mips_multicycle_controller_if.sv - control bus between the multicycle MIPS controller and datapath
//
// Purpose: bundles the opcode/handshake inputs and every datapath control
// output of the main control FSM.
// Ports (signals):
//   Op[5:0], MemReady                      datapath -> controller
//   IorD, MemWrite, IRWrite, RegDst,
//   MemtoReg, RegWrite, ALUSrcA,
//   ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0],
//   PCWrite, Branch, IllegalOp, State[3:0] controller -> datapath
// Modports: master = controller side, slave = datapath side.
interface mips_multicycle_controller_if;
   logic [5:0] Op;
   logic       MemReady;
   logic       IorD;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] PCSrc;
   logic       PCWrite;
   logic       Branch;
   logic       IllegalOp;
   logic [3:0] State;

   modport master (
      input  Op, MemReady,
      output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
             ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, IllegalOp, State
   );

   modport slave (
      output Op, MemReady,
      input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
             ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, IllegalOp, State
   );
endinterface

// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - main control FSM of the multicycle MIPS datapath
//
// Purpose: sequences fetch/decode/execute/memory/writeback from the opcode
// and drives the datapath enables and muxes; stalls on MemReady in FETCH,
// MEMRD and MEMWR.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high, forces FETCH
//   ctl    controller side of mips_multicycle_controller_if (see that file)
module mips_multicycle_controller (
   input  logic                           clk,
   input  logic                           reset,
   mips_multicycle_controller_if.master   ctl
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_e;

   state_e state_q, state_d;

   // Asynchronous reset: write strobes decode from state_q, so they drop
   // the moment reset rises rather than at the next edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = S_FETCH;
      ctl.IorD      = 1'b0;
      ctl.MemWrite  = 1'b0;
      ctl.IRWrite   = 1'b0;
      ctl.RegDst    = 1'b0;
      ctl.MemtoReg  = 1'b0;
      ctl.RegWrite  = 1'b0;
      ctl.ALUSrcA   = 1'b0;
      ctl.ALUSrcB   = 2'b00;
      ctl.ALUOp     = 2'b00;
      ctl.PCSrc     = 2'b00;
      ctl.PCWrite   = 1'b0;
      ctl.Branch    = 1'b0;
      ctl.IllegalOp = 1'b0;
      ctl.State     = state_q;

      case (state_q)
         S_FETCH: begin
            // PC+4 is computed every cycle; IR and PC only load once memory
            // has actually returned the instruction.
            ctl.ALUSrcB = 2'b01;
            ctl.IRWrite = ctl.MemReady;
            ctl.PCWrite = ctl.MemReady;
            state_d     = ctl.MemReady ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // Branch target precomputed into ALUOut while the opcode decodes.
            ctl.ALUSrcB = 2'b11;
            case (ctl.Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default: begin
                  ctl.IllegalOp = 1'b1;
                  state_d       = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ctl.ALUSrcA = 1'b1;
            ctl.ALUSrcB = 2'b10;
            state_d     = (ctl.Op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            ctl.IorD = 1'b1;
            state_d  = ctl.MemReady ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            ctl.MemtoReg = 1'b1;
            ctl.RegWrite = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEMWR: begin
            // Strobe stays up for the whole stall, not just the ready cycle.
            ctl.IorD     = 1'b1;
            ctl.MemWrite = 1'b1;
            state_d      = ctl.MemReady ? S_FETCH : S_MEMWR;
         end
         S_EXECUTE: begin
            ctl.ALUSrcA = 1'b1;
            ctl.ALUOp   = 2'b10;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            ctl.RegDst   = 1'b1;
            ctl.RegWrite = 1'b1;
            state_d      = S_FETCH;
         end
         S_BRANCH: begin
            ctl.ALUSrcA = 1'b1;
            ctl.ALUOp   = 2'b01;
            ctl.PCSrc   = 2'b01;
            ctl.Branch  = 1'b1;
            state_d     = S_FETCH;
         end
         S_ADDIEX: begin
            ctl.ALUSrcA = 1'b1;
            ctl.ALUSrcB = 2'b10;
            state_d     = S_ADDIWB;
         end
         S_ADDIWB: begin
            ctl.RegWrite = 1'b1;
            state_d      = S_FETCH;
         end
         S_JUMP: begin
            ctl.PCSrc   = 2'b10;
            ctl.PCWrite = 1'b1;
            state_d     = S_FETCH;
         end
         default: begin
            // Encodings 12-15: all outputs stay 0, recover to FETCH.
            state_d = S_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb/tb_mips_multicycle_controller.sv - scoreboard bench for mips_multicycle_controller
module tb_mips_multicycle_controller;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   logic clk;
   logic reset;
   int   compared;
   int   mismatched;

   mips_multicycle_controller_if bus ();

   mips_multicycle_controller dut (
      .clk   (clk),
      .reset (reset),
      .ctl   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed output vector:
   // {State[3:0], IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
   //  ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0], PCWrite, Branch, IllegalOp}
   typedef logic [19:0] vec_t;

   function automatic vec_t mk(input logic [3:0] st, input logic iord, input logic mw,
                               input logic irw, input logic rd, input logic m2r,
                               input logic rw, input logic sa, input logic [1:0] sb,
                               input logic [1:0] aop, input logic [1:0] pcs,
                               input logic pcw, input logic br, input logic ill);
      return {st, iord, mw, irw, rd, m2r, rw, sa, sb, aop, pcs, pcw, br, ill};
   endfunction

   // Expected outputs per state, written from the control table.
   function automatic vec_t exp_out(input logic [3:0] st, input logic mr, input logic [5:0] op);
      logic legal;
      legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
              (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
      case (st)
         4'd0:  return mk(4'd0,  0, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, mr, 0, 0);
         4'd1:  return mk(4'd1,  0, 0, 0,  0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0,  0, !legal);
         4'd2:  return mk(4'd2,  0, 0, 0,  0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0,  0, 0);
         4'd3:  return mk(4'd3,  1, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0);
         4'd4:  return mk(4'd4,  0, 0, 0,  0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0);
         4'd5:  return mk(4'd5,  1, 1, 0,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0);
         4'd6:  return mk(4'd6,  0, 0, 0,  0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0,  0, 0);
         4'd7:  return mk(4'd7,  0, 0, 0,  1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0);
         4'd8:  return mk(4'd8,  0, 0, 0,  0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0,  1, 0);
         4'd9:  return mk(4'd9,  0, 0, 0,  0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0,  0, 0);
         4'd10: return mk(4'd10, 0, 0, 0,  0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0);
         4'd11: return mk(4'd11, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1,  0, 0);
         default: return '0;
      endcase
   endfunction

   function automatic vec_t act_out();
      return {bus.State, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
              bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc,
              bus.PCWrite, bus.Branch, bus.IllegalOp};
   endfunction

   vec_t  exp_q[$];
   string name_q[$];

   // Monitor: one expected vector per cycle, compared on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         vec_t  e;
         vec_t  a;
         string n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         a = act_out();
         compared++;
         if (a !== e) begin
            mismatched++;
            $display("FAIL %s: actual %05h required %05h (state %0d vs %0d)",
                     n, a, e, a[19:16], e[19:16]);
         end
      end
   end

   // Drive one cycle of inputs just after the rising edge and queue what the
   // outputs must be during that cycle (st = state expected in that cycle).
   task automatic step(input string n, input logic [5:0] op, input logic mr, input logic [3:0] st);
      @(posedge clk);
      #1;
      bus.Op       = op;
      bus.MemReady = mr;
      exp_q.push_back(exp_out(st, mr, op));
      name_q.push_back(n);
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      reset        = 1'b1;
      bus.Op       = OP_LW;
      bus.MemReady = 1'b0;

      // Reset state: FETCH values, IRWrite/PCWrite following MemReady.
      step("rst_mr0", OP_LW, 1'b0, 4'd0);
      step("rst_mr1", OP_LW, 1'b1, 4'd0);
      step("rst_hold", OP_LW, 1'b0, 4'd0);
      #3 reset = 1'b0;

      // lw, one fetch stall and one read stall; Op changes in MEMRD ignored.
      step("lw_fstall", OP_LW,    1'b0, 4'd0);
      step("lw_fetch",  OP_LW,    1'b1, 4'd0);
      step("lw_decode", OP_LW,    1'b1, 4'd1);
      step("lw_memadr", OP_LW,    1'b1, 4'd2);
      step("lw_rstall", OP_RTYPE, 1'b0, 4'd3);
      step("lw_memrd",  OP_RTYPE, 1'b1, 4'd3);
      step("lw_memwb",  OP_RTYPE, 1'b1, 4'd4);

      // sw with three stall cycles in MEMWR.
      step("sw_fetch",  OP_SW, 1'b1, 4'd0);
      step("sw_decode", OP_SW, 1'b1, 4'd1);
      step("sw_memadr", OP_SW, 1'b1, 4'd2);
      step("sw_wr0",    OP_SW, 1'b0, 4'd5);
      step("sw_wr1",    OP_SW, 1'b0, 4'd5);
      step("sw_wr2",    OP_SW, 1'b0, 4'd5);
      step("sw_wr3",    OP_SW, 1'b1, 4'd5);

      // R-type.
      step("r_fetch",  OP_RTYPE, 1'b1, 4'd0);
      step("r_decode", OP_RTYPE, 1'b1, 4'd1);
      step("r_exec",   OP_RTYPE, 1'b1, 4'd6);
      step("r_aluwb",  OP_RTYPE, 1'b1, 4'd7);

      // beq.
      step("beq_fetch",  OP_BEQ, 1'b1, 4'd0);
      step("beq_decode", OP_BEQ, 1'b1, 4'd1);
      step("beq_branch", OP_BEQ, 1'b1, 4'd8);

      // Illegal opcode.
      step("ill_fetch",  OP_BAD, 1'b1, 4'd0);
      step("ill_decode", OP_BAD, 1'b1, 4'd1);

      // j.
      step("j_fetch",  OP_J, 1'b1, 4'd0);
      step("j_decode", OP_J, 1'b1, 4'd1);
      step("j_jump",   OP_J, 1'b1, 4'd11);

      // addi.
      step("addi_fetch",  OP_ADDI, 1'b1, 4'd0);
      step("addi_decode", OP_ADDI, 1'b1, 4'd1);
      step("addi_ex",     OP_ADDI, 1'b1, 4'd9);
      step("addi_wb",     OP_ADDI, 1'b1, 4'd10);

      // Reset mid-cycle while stalled in MEMWR.
      step("swr_fetch",  OP_SW, 1'b1, 4'd0);
      step("swr_decode", OP_SW, 1'b1, 4'd1);
      step("swr_memadr", OP_SW, 1'b1, 4'd2);
      @(posedge clk);
      #1;
      bus.MemReady = 1'b0;
      #1;
      compared++;
      if (bus.MemWrite !== 1'b1 || bus.State !== 4'd5) begin
         mismatched++;
         $display("FAIL swr_pre: actual MemWrite=%b State=%0d required MemWrite=1 State=5",
                  bus.MemWrite, bus.State);
      end
      reset = 1'b1;
      #1;
      compared++;
      if (bus.MemWrite !== 1'b0 || bus.RegWrite !== 1'b0 || bus.State !== 4'd0) begin
         mismatched++;
         $display("FAIL swr_async: actual MemWrite=%b RegWrite=%b State=%0d required 0 0 0",
                  bus.MemWrite, bus.RegWrite, bus.State);
      end
      exp_q.push_back(exp_out(4'd0, 1'b0, OP_SW));
      name_q.push_back("swr_reset_cycle");
      step("swr_in_reset", OP_SW, 1'b0, 4'd0);
      #3 reset = 1'b0;
      step("swr_after", OP_SW, 1'b1, 4'd0);
      step("swr_decode2", OP_SW, 1'b1, 4'd1);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain: actual %0d entries left required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "timeout");
   end

endmodule
